fetch_unit: RTL and testbench

//  Instruction fetch stage feeding the decoder. Issues Sysbus line reads, buffers one cache line,
//  and streams 32-bit instructions with their PC over a valid/ready handshake.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit port bundle: Sysbus line-read channel plus the instruction
// stream toward the decoder. The fetch unit is the master of both.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'b0001
`endif

interface fetch_unit_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_instr;
  logic [63:0]               out_pc;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output out_valid, out_instr, out_pc,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag, out_ready
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  out_valid, out_instr, out_pc,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one cache line over Sysbus, buffers it and
// streams 32-bit instructions with their PC to the decoder. Handles
// redirects (draining an in-flight line if needed) and halts on a zero word.
module fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   entry,
  input  logic          redirect_valid,
  input  logic [63:0]   redirect_pc,
  fetch_unit_if.master  bus,
  output logic          halted
);
  localparam int OFF = $clog2(LINE_BEATS * 8);
  localparam int BW  = $clog2(LINE_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [BUS_TAG_WIDTH-1:0] REQ_TAG = {1'b1, `SYSBUS_MEMORY, 8'h00};

  typedef enum logic [2:0] {IDLE, REQ, RESP, DRAIN, HALT} state_e;

  state_e                                       state_q, state_d;
  logic [63:0]                                  pc_q, pc_d;
  logic [63:0]                                  req_addr_q, req_addr_d;
  logic [BW-1:0]                                beat_cnt_q, beat_cnt_d;
  logic [LINE_BEATS-1:0]                        beat_valid_q, beat_valid_d;
  logic [LINE_BEATS-1:0][BUS_DATA_WIDTH-1:0]    line_q, line_d;
  logic                                         stale_q, stale_d;

  // Head of the stream: which beat/half of the line the current pc selects
  logic [BW-1:0] head_beat;
  logic [31:0]   head_instr;
  logic          head_ok;
  logic          head_last;
  logic          all_rcvd;
  logic          out_ok;
  logic          unused_ok;

  assign head_beat  = pc_q[OFF-1:3];
  assign head_instr = pc_q[2] ? line_q[head_beat][63:32] : line_q[head_beat][31:0];
  assign head_ok    = beat_valid_q[head_beat];
  assign head_last  = &pc_q[OFF-1:2];
  // The final beat may land in the same cycle as a redirect; count it
  assign all_rcvd   = (&beat_valid_q) | (bus.bus_respcyc & (beat_cnt_q == LAST_BEAT));
  assign unused_ok  = ^bus.bus_resptag;

  // Next-state, datapath updates and outputs; outputs forced low during reset
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    beat_cnt_d   = beat_cnt_q;
    beat_valid_d = beat_valid_q;
    line_d       = line_q;
    stale_d      = stale_q;
    out_ok       = 1'b0;
    bus.bus_reqcyc  = 1'b0;
    bus.bus_req     = '0;
    bus.bus_reqtag  = '0;
    bus.bus_respack = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_instr   = '0;
    bus.out_pc      = '0;
    halted          = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        bus.bus_reqcyc = 1'b1;
        bus.bus_req    = req_addr_q;
        bus.bus_reqtag = REQ_TAG;
        // The request stays up; the returning line is marked stale instead
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          stale_d = 1'b1;
        end
        if (bus.bus_reqack) begin
          state_d      = (stale_q | redirect_valid) ? DRAIN : RESP;
          beat_cnt_d   = '0;
          beat_valid_d = '0;
        end
      end
      RESP: begin
        bus.bus_respack = bus.bus_respcyc;
        if (bus.bus_respcyc) begin
          line_d[beat_cnt_q]       = bus.bus_resp;
          beat_valid_d[beat_cnt_q] = 1'b1;
          beat_cnt_d               = beat_cnt_q + BW'(1);
        end
        out_ok        = head_ok && !redirect_valid && (head_instr != 32'd0);
        bus.out_valid = out_ok;
        bus.out_instr = head_instr;
        bus.out_pc    = pc_q;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = all_rcvd ? REQ : DRAIN;
        end else if (head_ok && head_instr == 32'd0) begin
          state_d = HALT;
        end else if (out_ok && bus.out_ready) begin
          pc_d = pc_q + 64'd4;
          if (head_last) state_d = REQ;
        end
      end
      DRAIN: begin
        bus.bus_respack = bus.bus_respcyc;
        if (bus.bus_respcyc) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            stale_d = 1'b0;
            state_d = REQ;
          end
        end
        if (redirect_valid) pc_d = redirect_pc;
      end
      HALT: halted = 1'b1;
      default: state_d = IDLE;
    endcase

    // Latch the line address on every entry into REQ
    if (state_d == REQ && state_q != REQ)
      req_addr_d = {pc_d[63:OFF], {OFF{1'b0}}};

    if (reset) begin
      bus.bus_reqcyc  = 1'b0;
      bus.bus_req     = '0;
      bus.bus_reqtag  = '0;
      bus.bus_respack = 1'b0;
      bus.out_valid   = 1'b0;
      bus.out_instr   = '0;
      bus.out_pc      = '0;
      halted          = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= entry;
      req_addr_q   <= '0;
      beat_cnt_q   <= '0;
      beat_valid_q <= '0;
      line_q       <= '0;
      stale_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      beat_valid_q <= beat_valid_d;
      line_q       <= line_d;
      stale_q      <= stale_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a bus/decoder model driven step by step,
// expected instruction stream held in a queue built from constants.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halted;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] exp_pc[$];
  logic [31:0] exp_in[$];
  logic        ov;

  localparam logic [31:0] B1 = 32'h1100_0000;
  localparam logic [31:0] B2 = 32'h2200_0000;
  localparam logic [31:0] B3 = 32'h3300_0000;
  localparam logic [31:0] B4 = 32'h4400_0000;
  localparam logic [31:0] B5 = 32'h5500_0000;
  localparam logic [31:0] B6 = 32'h6600_0000;
  localparam logic [31:0] B7 = 32'h7700_0000;
  localparam logic [31:0] BZ = 32'hFFFF_FFFC;  // beat 2 low word wraps to 0

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [31:0] base, input int k);
    logic [31:0] lo, hi;
    lo = base + 32'(2 * k);
    hi = base + 32'(2 * k + 1);
    return {hi, lo};
  endfunction

  // Expected stream: instruction index within the line is added to base
  task automatic push_range(input logic [63:0] line, input logic [63:0] first,
                            input logic [63:0] last, input logic [31:0] base);
    for (logic [63:0] p = first; p <= last; p += 64'd4) begin
      exp_pc.push_back(p);
      exp_in.push_back(base + 32'((p - line) >> 2));
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs just after
  task automatic tick(input logic cyc, input logic [63:0] d, input logic rdy,
                      input logic rv, input logic [63:0] rpc, input logic ack);
    @(negedge clk);
    bus.bus_respcyc = cyc;
    bus.bus_resp    = d;
    bus.out_ready   = rdy;
    bus.bus_reqack  = ack;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    #1;
    ov = bus.out_valid;
    if (cyc) chk("respack", 64'(bus.bus_respack), 64'd1);
    if (bus.out_valid && rdy) begin
      if (exp_pc.size() == 0) chk("extra_out", 64'(bus.out_valid), 64'd0);
      else begin
        chk("out_pc", bus.out_pc, exp_pc.pop_front());
        chk("out_instr", 64'(bus.out_instr), 64'(exp_in.pop_front()));
      end
    end
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 64'd0, rdy, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic send_beats(input logic [31:0] base, input int from, input int to, input logic rdy);
    for (int k = from; k <= to; k++) tick(1'b1, beat(base, k), rdy, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic wait_req(input logic [63:0] addr, input logic ack);
    int i = 0;
    while (!bus.bus_reqcyc && i < 20) begin
      idle(1'b1);
      i++;
    end
    chk("reqcyc", 64'(bus.bus_reqcyc), 64'd1);
    chk("req_addr", bus.bus_req, addr);
    chk("reqtag", 64'(bus.bus_reqtag), 64'h1100);
    if (ack) tick(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
  endtask

  task automatic drain();
    int i = 0;
    while (exp_pc.size() != 0 && i < 60) begin
      idle(1'b1);
      i++;
    end
    chk("stream_done", 64'(exp_pc.size()), 64'd0);
  endtask

  task automatic do_reset(input logic [63:0] e);
    @(negedge clk);
    reset           = 1'b1;
    entry           = e;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    bus.bus_reqack  = 1'b0;
    bus.bus_respcyc = 1'b0;
    bus.bus_resp    = 64'd0;
    bus.bus_resptag = 13'd0;
    bus.out_ready   = 1'b0;
    @(negedge clk);
    chk("rst_reqcyc", 64'(bus.bus_reqcyc), 64'd0);
    chk("rst_req", bus.bus_req, 64'd0);
    chk("rst_valid_halt", {62'd0, bus.out_valid, halted}, 64'd0);
    reset = 1'b0;
  endtask

  initial begin
    // 1: aligned entry, full line, no stall, then next sequential line
    do_reset(64'h1000);
    wait_req(64'h1000, 1'b1);
    push_range(64'h1000, 64'h1000, 64'h103C, B1);
    tick(1'b1, beat(B1, 0), 1'b1, 1'b0, 64'd0, 1'b0);
    chk("t1_no_bypass", 64'(ov), 64'd0);
    send_beats(B1, 1, 7, 1'b1);
    drain();
    wait_req(64'h1040, 1'b0);

    // 2: unaligned entry skips the first five instructions
    do_reset(64'h1014);
    wait_req(64'h1000, 1'b1);
    push_range(64'h1000, 64'h1014, 64'h103C, B2);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, beat(B2, k), 1'b1, 1'b0, 64'd0, 1'b0);
      chk("t2_not_yet", 64'(ov), 64'd0);
    end
    tick(1'b1, beat(B2, 3), 1'b1, 1'b0, 64'd0, 1'b0);
    chk("t2_first", 64'(ov), 64'd1);
    send_beats(B2, 4, 7, 1'b1);
    drain();

    // 3: decoder stalls 20 cycles while all beats arrive
    do_reset(64'h1000);
    wait_req(64'h1000, 1'b1);
    push_range(64'h1000, 64'h1000, 64'h103C, B3);
    send_beats(B3, 0, 7, 1'b0);
    repeat (12) idle(1'b0);
    chk("t3_hold_pc", bus.out_pc, 64'h1000);
    chk("t3_hold_valid", 64'(ov), 64'd1);
    drain();

    // 4: redirect after beat 3; remaining beats drained, new line fetched
    do_reset(64'h1000);
    wait_req(64'h1000, 1'b1);
    push_range(64'h1000, 64'h1000, 64'h1008, B4);
    send_beats(B4, 0, 3, 1'b1);
    tick(1'b0, 64'd0, 1'b1, 1'b1, 64'h2008, 1'b0);
    chk("t4_redir_ov", 64'(ov), 64'd0);
    chk("t4_consumed", 64'(exp_pc.size()), 64'd0);
    for (int k = 4; k < 8; k++) begin
      tick(1'b1, beat(B4, k), 1'b1, 1'b0, 64'd0, 1'b0);
      chk("t4_drain_ov", 64'(ov), 64'd0);
    end
    wait_req(64'h2000, 1'b1);
    push_range(64'h2000, 64'h2008, 64'h203C, B5);
    send_beats(B5, 0, 7, 1'b1);
    drain();

    // 5: redirect while the request is pending; stale line fully drained
    do_reset(64'h1000);
    wait_req(64'h1000, 1'b0);
    tick(1'b0, 64'd0, 1'b1, 1'b1, 64'h3004, 1'b0);
    idle(1'b1);
    chk("t5_req_held", bus.bus_req, 64'h1000);
    chk("t5_reqcyc_held", 64'(bus.bus_reqcyc), 64'd1);
    tick(1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, beat(B6, k), 1'b1, 1'b0, 64'd0, 1'b0);
      chk("t5_drain_ov", 64'(ov), 64'd0);
    end
    wait_req(64'h3000, 1'b1);
    push_range(64'h3000, 64'h3004, 64'h303C, B7);
    send_beats(B7, 0, 7, 1'b1);
    drain();

    // 6: zero instruction at head halts the unit for good
    do_reset(64'h1000);
    wait_req(64'h1000, 1'b1);
    push_range(64'h1000, 64'h1000, 64'h100C, BZ);
    send_beats(BZ, 0, 5, 1'b1);
    chk("t6_zero_ov", 64'(ov), 64'd0);
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      chk("t6_halted", 64'(halted), 64'd1);
      chk("t6_no_req", {62'd0, bus.bus_reqcyc, bus.out_valid}, 64'd0);
    end
    chk("t6_stream", 64'(exp_pc.size()), 64'd0);

    // 7: reset in the middle of a response; in-flight beat not acked
    do_reset(64'h1000);
    chk("t7_halt_cleared", 64'(halted), 64'd0);
    wait_req(64'h1000, 1'b1);
    send_beats(B1, 0, 2, 1'b0);
    @(negedge clk);
    reset           = 1'b1;
    entry           = 64'h5010;
    bus.bus_respcyc = 1'b1;
    bus.bus_resp    = beat(B1, 3);
    #1;
    chk("t7_respack", 64'(bus.bus_respack), 64'd0);
    chk("t7_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    bus.bus_respcyc = 1'b0;
    #1;
    chk("t7_out_pc", bus.out_pc, 64'd0);
    chk("t7_out_instr", 64'(bus.out_instr), 64'd0);
    chk("t7_reqtag", 64'(bus.bus_reqtag), 64'd0);
    reset = 1'b0;
    wait_req(64'h5000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
